// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detection window monitor.
package seq_pkg;

  // Default widths: per-window count/threshold, window length, running total.
  localparam int DEF_CNT_W = 8;
  localparam int DEF_WIN_W = 16;
  localparam int DEF_TOT_W = 16;

  // Monitor FSM encoding; the unused code 3 falls back to IDLE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    ALARM  = 2'd2
  } mon_state_t;

endpackage

// File: rtl/seq_window_monitor_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load_zero,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Clearing takes precedence over counting; counting stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || i_load_zero) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_window_monitor.sv
// Rate monitor on the 1011 detector strobe.
//
// state  | meaning
// IDLE   | no window running; waits for enable with a non-zero win_len
// WINDOW | sampling seq_seen for win_len cycles, windows back-to-back
// ALARM  | a window count reached threshold; held until clear or reset
module seq_window_monitor
  import seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int WIN_W = DEF_WIN_W,
  parameter int TOT_W = DEF_TOT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seq_seen,
  input  logic             enable,
  input  logic             clear,
  input  logic [WIN_W-1:0] win_len,
  input  logic [CNT_W-1:0] threshold,
  output logic [CNT_W-1:0] match_count,
  output logic [TOT_W-1:0] total_count,
  output logic             window_done,
  output logic             alarm,
  output logic             busy
);

  mon_state_t       r_state;
  mon_state_t       w_state_nxt;
  logic [WIN_W-1:0] r_win_cnt;
  logic [WIN_W-1:0] w_win_cnt_nxt;
  logic [CNT_W-1:0] r_match_count;
  logic [CNT_W-1:0] w_match_nxt;
  logic             r_window_done;
  logic             w_done_nxt;
  logic             r_alarm;
  logic             w_alarm_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             w_wm_load_zero;
  logic             w_wm_inc;
  logic [CNT_W-1:0] w_win_match;
  logic [CNT_W-1:0] w_final;
  logic [TOT_W-1:0] w_total;

  // Matches seen so far in the current window.
  sat_counter #(.W(CNT_W)) u_win_match (
    .clk         (clk),
    .rst_n       (reset),
    .i_clr       (clear),
    .i_load_zero (w_wm_load_zero),
    .i_inc       (w_wm_inc),
    .o_cnt       (w_win_match)
  );

  // Free-running total; counts in every state, including ALARM.
  sat_counter #(.W(TOT_W)) u_total (
    .clk         (clk),
    .rst_n       (reset),
    .i_clr       (clear),
    .i_load_zero (1'b0),
    .i_inc       (seq_seen),
    .o_cnt       (w_total)
  );

  // Window result including the last cycle's strobe, saturated.
  assign w_final = (w_win_match == {CNT_W{1'b1}}) ? w_win_match
                 : w_win_match + {{(CNT_W-1){1'b0}}, seq_seen};

  // Next-state, window counter and registered-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_win_cnt_nxt  = r_win_cnt;
    w_match_nxt    = r_match_count;
    w_done_nxt     = 1'b0;
    w_alarm_nxt    = r_alarm;
    w_wm_load_zero = 1'b0;
    w_wm_inc       = 1'b0;
    if (clear) begin
      w_state_nxt   = IDLE;
      w_win_cnt_nxt = '0;
      w_match_nxt   = '0;
      w_alarm_nxt   = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          w_alarm_nxt = 1'b0;
          if (enable && (win_len != '0)) begin
            w_win_cnt_nxt  = win_len - 1'b1;
            w_wm_load_zero = 1'b1;
            w_state_nxt    = WINDOW;
          end
        end
        WINDOW: begin
          if (!enable) begin
            w_state_nxt = IDLE;
          end else if (r_win_cnt != '0) begin
            w_wm_inc      = seq_seen;
            w_win_cnt_nxt = r_win_cnt - 1'b1;
          end else begin
            w_match_nxt = w_final;
            w_done_nxt  = 1'b1;
            if ((threshold != '0) && (w_final >= threshold)) begin
              w_alarm_nxt = 1'b1;
              w_state_nxt = ALARM;
            end else if (win_len != '0) begin
              // Back-to-back window, no gap cycle.
              w_win_cnt_nxt  = win_len - 1'b1;
              w_wm_load_zero = 1'b1;
            end else begin
              w_state_nxt = IDLE;
            end
          end
        end
        ALARM: begin
          w_alarm_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
    w_busy_nxt = (w_state_nxt == WINDOW);
  end

  // State, window counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_win_cnt     <= '0;
      r_match_count <= '0;
      r_window_done <= 1'b0;
      r_alarm       <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_win_cnt     <= w_win_cnt_nxt;
      r_match_count <= w_match_nxt;
      r_window_done <= w_done_nxt;
      r_alarm       <= w_alarm_nxt;
      r_busy        <= w_busy_nxt;
    end
  end

  assign match_count = r_match_count;
  assign total_count = w_total;
  assign window_done = r_window_done;
  assign alarm       = r_alarm;
  assign busy        = r_busy;

endmodule

// File: tb/tb_seq_window_monitor.sv
// Directed bench for the window monitor; a second instance with a narrow total
// counter exercises total saturation in a short run.
module tb_seq_window_monitor;

  logic        clk;
  logic        reset;
  logic        seq_seen;
  logic        enable;
  logic        clear;
  logic [15:0] win_len;
  logic [7:0]  threshold;
  logic [7:0]  match_count;
  logic [15:0] total_count;
  logic        window_done;
  logic        alarm;
  logic        busy;
  logic [7:0]  sm_match_count;
  logic [5:0]  sm_total_count;
  logic        sm_window_done;
  logic        sm_alarm;
  logic        sm_busy;

  int n_checks;
  int n_errors;
  int tot;

  seq_window_monitor u_dut (
    .clk         (clk),
    .reset       (reset),
    .seq_seen    (seq_seen),
    .enable      (enable),
    .clear       (clear),
    .win_len     (win_len),
    .threshold   (threshold),
    .match_count (match_count),
    .total_count (total_count),
    .window_done (window_done),
    .alarm       (alarm),
    .busy        (busy)
  );

  seq_window_monitor #(.TOT_W(6)) u_dut_sm (
    .clk         (clk),
    .reset       (reset),
    .seq_seen    (seq_seen),
    .enable      (enable),
    .clear       (clear),
    .win_len     (win_len),
    .threshold   (threshold),
    .match_count (sm_match_count),
    .total_count (sm_total_count),
    .window_done (sm_window_done),
    .alarm       (sm_alarm),
    .busy        (sm_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge and track the total.
  task automatic step(input logic s, input logic en, input logic clr);
    seq_seen = s;
    enable   = en;
    clear    = clr;
    @(posedge clk);
    #1;
    if (clr) tot = 0;
    else if (s) tot++;
  endtask

  function automatic int sat_tot(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    tot       = 0;
    reset     = 1'b0;
    seq_seen  = 1'b1;
    enable    = 1'b1;
    clear     = 1'b0;
    win_len   = 16'd0;
    threshold = 8'd0;

    // Reset held with activity on the inputs.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_match", match_count, 0);
    chk("rst_total", total_count, 0);
    chk("rst_done", window_done, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;

    // win_len=0 with enable keeps the FSM idle; total starts from 0.
    step(1, 1, 0);
    chk("tot_after_rst", total_count, 1);
    chk("wl0_busy", busy, 0);
    step(0, 1, 0);
    chk("wl0_busy2", busy, 0);
    step(0, 0, 1);
    chk("clr_total", total_count, 0);

    // Basic window: pulses at cycles 1, 4, 10 of a 10-cycle window.
    win_len = 16'd10;
    threshold = 8'd0;
    step(0, 1, 0);
    chk("basic_busy", busy, 1);
    for (int k = 1; k <= 10; k++) begin
      step((k == 1) || (k == 4) || (k == 10), 1, 0);
      if (k < 10) chk("basic_done_early", window_done, 0);
    end
    chk("basic_match", match_count, 3);
    chk("basic_done", window_done, 1);
    chk("basic_nogap_busy", busy, 1);
    chk("basic_alarm", alarm, 0);
    chk("basic_total", total_count, sat_tot(tot, 65535));
    // Second window follows immediately; single pulse at cycle 2.
    for (int k = 1; k <= 10; k++) begin
      step(k == 2, 1, 0);
      if (k == 1) chk("win2_done_drop", window_done, 0);
    end
    chk("win2_match", match_count, 1);
    chk("win2_done", window_done, 1);
    step(0, 0, 0);
    chk("win3_abort_busy", busy, 0);
    chk("win3_abort_done", window_done, 0);

    // Abort: 20-cycle window, enable dropped in cycle 5 after 2 pulses.
    win_len = 16'd20;
    step(0, 1, 0);
    for (int k = 1; k <= 4; k++) step((k == 1) || (k == 3), 1, 0);
    step(1, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", window_done, 0);
    chk("abort_match", match_count, 1);
    chk("abort_total", total_count, sat_tot(tot, 65535));

    // Alarm: two pulses in an 8-cycle window with threshold 2.
    win_len = 16'd8;
    threshold = 8'd2;
    step(0, 1, 0);
    for (int k = 1; k <= 8; k++) step((k == 3) || (k == 6), 1, 0);
    chk("alarm_match", match_count, 2);
    chk("alarm_done", window_done, 1);
    chk("alarm_set", alarm, 1);
    chk("alarm_busy", busy, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    chk("alarm_hold", alarm, 1);
    chk("alarm_hold_busy", busy, 0);
    chk("alarm_hold_done", window_done, 0);
    chk("alarm_hold_match", match_count, 2);
    chk("alarm_total", total_count, sat_tot(tot, 65535));
    step(0, 0, 1);
    chk("alarm_clr", alarm, 0);
    chk("alarm_clr_total", total_count, 0);
    chk("alarm_clr_match", match_count, 0);
    chk("alarm_clr_busy", busy, 0);

    // win_len=1: every cycle is a complete window.
    threshold = 8'd0;
    win_len = 16'd1;
    step(0, 1, 0);
    for (int k = 0; k < 4; k++) begin
      logic [3:0] pat;
      pat = 4'b1101;
      step(pat[k], 1, 0);
      chk("wl1_match", match_count, {7'd0, pat[k]});
      chk("wl1_done", window_done, 1);
      chk("wl1_busy", busy, 1);
    end
    step(0, 0, 0);
    chk("wl1_stop_busy", busy, 0);
    chk("wl1_stop_done", window_done, 0);

    // Saturation: 150 pulses in 300 cycles, then 300 in 600 cycles.
    win_len = 16'd300;
    step(0, 1, 0);
    for (int k = 1; k <= 300; k++) step(k[0], 1, 0);
    chk("sat_150", match_count, 150);
    chk("sat_150_done", window_done, 1);
    step(0, 0, 0);
    win_len = 16'd600;
    step(0, 1, 0);
    for (int k = 1; k <= 600; k++) step(k[0], 1, 0);
    chk("sat_255", match_count, 255);
    step(0, 0, 0);
    chk("sat_total", total_count, sat_tot(tot, 65535));
    chk("sat_total6", sm_total_count, sat_tot(tot, 63));
    chk("sat_sm_busy", sm_busy, 0);

    // Clear coinciding with the last-cycle strobe of an alarming window.
    threshold = 8'd1;
    win_len = 16'd4;
    step(0, 1, 0);
    for (int k = 1; k <= 3; k++) step(0, 1, 0);
    step(1, 1, 1);
    chk("clrlast_match", match_count, 0);
    chk("clrlast_total", total_count, 0);
    chk("clrlast_alarm", alarm, 0);
    chk("clrlast_busy", busy, 0);
    chk("clrlast_done", window_done, 0);
    step(0, 0, 0);
    chk("clrlast_alarm2", alarm, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
